// File: rtl/ws_multi_string_driver_pkg.sv
// Shared timing defaults, FSM encoding and count helpers for the parallel WS2812B/SK6812 driver.
package ws_multi_string_driver_pkg;

    localparam int DEF_CLK_PERIOD_NS = 100;
    localparam int DEF_T0H_NS        = 400;
    localparam int DEF_T1H_NS        = 800;
    localparam int DEF_BIT_NS        = 1250;
    localparam int DEF_LATCH_NS      = 50000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } ws_state_e;

    // Rounds up so a pulse is never shorter than the requested time.
    function automatic int get_count(input int t_ns, input int clk_ns);
        return (t_ns + clk_ns - 1) / clk_ns;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws_bit_timer.sv
// Shared phase/latch counter: cleared by the FSM, free-running otherwise, with the compares it needs.
module ws_bit_timer #(
    parameter int CNT_W     = 9,
    parameter int T0_CNT    = 4,
    parameter int T1_CNT    = 8,
    parameter int BIT_CNT   = 13,
    parameter int LATCH_CNT = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_tc,
    output logic o_latch_tc,
    output logic o_lt_t0,
    output logic o_lt_t1
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_count <= '0;
        else if (i_clear) r_count <= '0;
        else              r_count <= r_count + 1'b1;
    end

    assign o_bit_tc   = (r_count == CNT_W'(BIT_CNT - 1));
    assign o_latch_tc = (r_count == CNT_W'(LATCH_CNT - 1));
    assign o_lt_t0    = (r_count < CNT_W'(T0_CNT));
    assign o_lt_t1    = (r_count < CNT_W'(T1_CNT));

endmodule

// File: rtl/ws_multi_string_driver.sv
// Parallel WS2812B/SK6812 driver: one word per string shifted out in lockstep, with a one-deep
// holding register for gapless words, an explicit latch pulse and an underrun status pulse.
module ws_multi_string_driver
    import ws_multi_string_driver_pkg::*;
#(
    parameter int N_STRINGS      = 8,
    parameter int BITS_PER_PIXEL = 24,
    parameter int CLK_PERIOD_NS  = DEF_CLK_PERIOD_NS,
    parameter int T0H_NS         = DEF_T0H_NS,
    parameter int T1H_NS         = DEF_T1H_NS,
    parameter int BIT_NS         = DEF_BIT_NS,
    parameter int LATCH_NS       = DEF_LATCH_NS,
    parameter bit SDI_INVERT     = 1'b0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_STRINGS*BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                                pixel_valid,
    output logic                                pixel_ready,
    input  logic                                latch_valid,
    output logic                                latch_ready,
    output logic                                busy,
    output logic                                underrun,
    output logic [N_STRINGS-1:0]                sdi
);

    localparam int T0_CNT    = get_count(T0H_NS, CLK_PERIOD_NS);
    localparam int T1_CNT    = get_count(T1H_NS, CLK_PERIOD_NS);
    localparam int BIT_CNT   = get_count(BIT_NS, CLK_PERIOD_NS);
    localparam int LATCH_CNT = get_count(LATCH_NS, CLK_PERIOD_NS);
    localparam int CNT_W     = $clog2(max_int(BIT_CNT, LATCH_CNT) + 1);
    localparam int IDX_W     = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int WORD_W    = N_STRINGS * BITS_PER_PIXEL;

    if (T0_CNT >= T1_CNT || T1_CNT >= BIT_CNT) begin : g_bad_timing
        $error("ws_multi_string_driver: bit timing requires T0_CNT < T1_CNT < BIT_CNT");
    end

    ws_state_e          r_state;
    logic [WORD_W-1:0]  r_hold;
    logic               r_hold_full;
    logic [WORD_W-1:0]  r_shift;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [N_STRINGS-1:0] r_sdi;
    logic               r_underrun;

    logic               w_bit_tc, w_latch_tc, w_lt_t0, w_lt_t1;
    logic               w_last_bit, w_word_end, w_pixel_acc, w_latch_acc, w_unload, w_timer_clear;
    logic [WORD_W-1:0]  w_shifted;
    logic [N_STRINGS-1:0] w_sdi_next;

    assign w_last_bit    = (r_bit_idx == IDX_W'(BITS_PER_PIXEL - 1));
    assign w_word_end    = (r_state == ST_SHIFT) && w_bit_tc && w_last_bit;
    assign w_pixel_acc   = pixel_valid && !r_hold_full;
    assign w_latch_acc   = latch_valid && latch_ready;
    assign w_unload      = r_hold_full && ((r_state == ST_IDLE) || w_word_end);
    assign w_timer_clear = (r_state == ST_IDLE)
                        || ((r_state == ST_SHIFT) && w_bit_tc)
                        || ((r_state == ST_LATCH) && w_latch_tc);

    ws_bit_timer #(
        .CNT_W     (CNT_W),
        .T0_CNT    (T0_CNT),
        .T1_CNT    (T1_CNT),
        .BIT_CNT   (BIT_CNT),
        .LATCH_CNT (LATCH_CNT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_timer_clear),
        .o_bit_tc   (w_bit_tc),
        .o_latch_tc (w_latch_tc),
        .o_lt_t0    (w_lt_t0),
        .o_lt_t1    (w_lt_t1)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_sdi_next = {N_STRINGS{SDI_INVERT}};
        w_shifted  = '0;
        for (int i = 0; i < N_STRINGS; i++) begin
            w_shifted[i*BITS_PER_PIXEL +: BITS_PER_PIXEL] = r_shift[i*BITS_PER_PIXEL +: BITS_PER_PIXEL] << 1;
            if (r_state == ST_SHIFT)
                w_sdi_next[i] = (w_lt_t0 | (r_shift[i*BITS_PER_PIXEL + BITS_PER_PIXEL - 1] & w_lt_t1))
                              ^ SDI_INVERT;
        end
    end

    // NOTE: word storage carries no reset; the reset-cleared state and hold_full qualify its contents.
    always_ff @(posedge clk) begin
        if (w_pixel_acc) r_hold <= pixel_data;
        if (w_unload)
            r_shift <= r_hold;
        else if ((r_state == ST_SHIFT) && w_bit_tc)
            r_shift <= w_shifted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hold_full <= 1'b0;
            r_bit_idx   <= '0;
            r_sdi       <= {N_STRINGS{SDI_INVERT}};
            r_underrun  <= 1'b0;
        end else begin
            r_sdi       <= w_sdi_next;
            r_underrun  <= 1'b0;
            r_hold_full <= (r_hold_full && !w_unload) || w_pixel_acc;
            case (r_state)
                ST_IDLE: begin
                    r_bit_idx <= '0;
                    if (r_hold_full)      r_state <= ST_SHIFT;
                    else if (w_latch_acc) r_state <= ST_LATCH;
                end
                ST_SHIFT: begin
                    if (w_bit_tc) begin
                        if (w_last_bit) begin
                            r_bit_idx <= '0;
                            // A pending latch request counts as a planned end of sequence.
                            if (!r_hold_full) begin
                                r_state    <= ST_IDLE;
                                r_underrun <= !latch_valid;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_LATCH: if (w_latch_tc) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign pixel_ready = !r_hold_full;
    assign latch_ready = (r_state == ST_IDLE) && !r_hold_full && !pixel_valid;
    assign busy        = (r_state != ST_IDLE);
    assign underrun    = r_underrun;
    assign sdi         = r_sdi;

endmodule
